slot_serial_tx: RTL and testbench

SLOT_SERIAL_TX -- requirements
Module: slot_serial_tx

---
 rtl/slot_pkg.sv | 28 ++
 rtl/slot_bit_tick.sv | 26 ++
 rtl/slot_serial_tx.sv | 118 +++++++++++
 tb/tb_slot_serial_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// Shared definitions for the slot-machine serial transmitter.
// Optional feature: SLOT_TX_PARITY_EN adds an even-parity bit after the data.
package slot_pkg;

  localparam int REEL_W       = 3;
  localparam int NUM_REELS    = 4;
  localparam int FRAME_DATA_W = REEL_W * NUM_REELS;
  localparam int BIT_CNT_W    = 4;

  // 3-bit FSM state encoding
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
`ifdef SLOT_TX_PARITY_EN
  localparam state_t ST_PARITY = 3'd3;
`endif
  localparam state_t ST_STOP   = 3'd4;

`ifdef SLOT_TX_PARITY_EN
  // Even parity: the transmitted parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [FRAME_DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/slot_bit_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
// clear holds the count at zero so the first bit of a frame gets a full period.
module slot_bit_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  // Free-running period counter, wrapping at LAST
  always_ff @(posedge clk) begin
    if (reset || clear) r_cnt <= '0;
    else if (tick)      r_cnt <= '0;
    else                r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/slot_serial_tx.sv
// Serial transmitter for a 4-reel slot result: start bit, 12 data bits LSB
// first, optional even parity (SLOT_TX_PARITY_EN), stop bit. Line idles high.
module slot_serial_tx
  import slot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [2:0] reel0,
  input  logic [2:0] reel1,
  input  logic [2:0] reel2,
  input  logic [2:0] reel3,
  output logic       tx_ready,
  output logic       data_out,
  output logic       busy,
  output logic       done
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_DATA_W - 1);

  state_t                  r_state;
  logic [FRAME_DATA_W-1:0] r_shreg;
  logic [BIT_CNT_W-1:0]    r_bit_cnt;
  logic                    w_tick;
  logic                    w_idle;
  logic                    w_accept;
  logic [FRAME_DATA_W-1:0] w_frame;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && tx_valid;
  assign w_frame  = {reel3, reel2, reel1, reel0};

  // Timer held clear while idle, so it starts at 0 in the first START cycle
  slot_bit_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(w_idle),
    .tick (w_tick)
  );

`ifdef SLOT_TX_PARITY_EN
  logic r_parity;

  // Parity captured alongside the data so the shift register can drain freely
  always_ff @(posedge clk) begin
    if (reset)         r_parity <= 1'b0;
    else if (w_accept) r_parity <= even_parity(w_frame);
  end
`endif

  // Frame sequencer: shift register, bit counter and state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (tx_valid) begin
            r_shreg   <= w_frame;
            r_bit_cnt <= '0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shreg <= r_shreg >> 1;
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
`ifdef SLOT_TX_PARITY_EN
              r_state   <= ST_PARITY;
`else
              r_state   <= ST_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
`ifdef SLOT_TX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) r_state <= ST_STOP;
        end
`endif
        ST_STOP: begin
          if (w_tick) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Line level decoded from state; data bits come from the shift register LSB
  always_comb begin
    data_out = 1'b1;
    case (r_state)
      ST_START:  data_out = 1'b0;
      ST_DATA:   data_out = r_shreg[0];
`ifdef SLOT_TX_PARITY_EN
      ST_PARITY: data_out = r_parity;
`endif
      default:   data_out = 1'b1;
    endcase
  end

  assign tx_ready = w_idle;
  assign busy     = !w_idle;
  assign done     = (r_state == ST_STOP) && w_tick;

endmodule

// File: tb/tb_slot_serial_tx.sv
// Scoreboard bench for slot_serial_tx: one instance at 4 clocks/bit, one at 1.
// Stimulus pushes expected frames; a monitor per instance checks every cycle.
module tb_slot_serial_tx;

`ifdef SLOT_TX_PARITY_EN
  localparam int NB = 15;
`else
  localparam int NB = 14;
`endif

  typedef struct {
    logic [14:0] bits;   // bit i = i-th bit on the line
    int          abort;  // cycle in which reset is applied, 0 = none
    bit          b2b;    // next frame must start right after one idle cycle
  } frame_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_valid_a = 1'b0, tx_valid_b = 1'b0;
  logic [2:0] r0a = '0, r1a = '0, r2a = '0, r3a = '0;
  logic [2:0] r0b = '0, r1b = '0, r2b = '0, r3b = '0;
  logic tx_ready_a, data_out_a, busy_a, done_a;
  logic tx_ready_b, data_out_b, busy_b, done_b;

  int n_cmp = 0;
  int n_bad = 0;
  frame_t qa[$];
  frame_t qb[$];

  always #5 clk = ~clk;

  slot_serial_tx #(.CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .reset(reset), .tx_valid(tx_valid_a),
    .reel0(r0a), .reel1(r1a), .reel2(r2a), .reel3(r3a),
    .tx_ready(tx_ready_a), .data_out(data_out_a), .busy(busy_a), .done(done_a));

  slot_serial_tx #(.CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .reset(reset), .tx_valid(tx_valid_b),
    .reel0(r0b), .reel1(r1b), .reel2(r2b), .reel3(r3b),
    .tx_ready(tx_ready_b), .data_out(data_out_b), .busy(busy_b), .done(done_b));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop 1
  function automatic logic [14:0] model(input logic [2:0] a, b, c, d);
    logic [11:0] dat;
    logic [14:0] v;
    dat = {d, c, b, a};
    v = '0;
    for (int i = 0; i < 12; i++) v[i+1] = dat[i];
`ifdef SLOT_TX_PARITY_EN
    v[13] = ^dat;
    v[14] = 1'b1;
`else
    v[13] = 1'b1;
`endif
    return v;
  endfunction

  function automatic frame_t mkf(input logic [14:0] b, input int ab, input bit bb);
    frame_t f;
    f.bits = b; f.abort = ab; f.b2b = bb;
    return f;
  endfunction

  function automatic logic s_busy(input int w);  return (w == 0) ? busy_a : busy_b; endfunction
  function automatic logic s_dout(input int w);  return (w == 0) ? data_out_a : data_out_b; endfunction
  function automatic logic s_done(input int w);  return (w == 0) ? done_a : done_b; endfunction
  function automatic logic s_ready(input int w); return (w == 0) ? tx_ready_a : tx_ready_b; endfunction
  function automatic int   q_size(input int w);  return (w == 0) ? qa.size() : qb.size(); endfunction
  function automatic frame_t q_pop(input int w);
    if (w == 0) return qa.pop_front();
    return qb.pop_front();
  endfunction

  // Per-instance monitor: pops an expectation whenever a frame starts
  task automatic monitor(input int w);
    frame_t f;
    int cpb, total;
    bit pending;
    string tag;
    cpb = (w == 0) ? 4 : 1;
    tag = (w == 0) ? "A" : "B";
    pending = 1'b0;
    forever begin
      if (!pending) @(negedge clk);
      pending = 1'b0;
      if (s_busy(w)) begin
        if (q_size(w) == 0) begin
          flag_fail({"unexpected_frame_", tag});
          while (s_busy(w)) @(negedge clk);
        end else begin
          f = q_pop(w);
          total = NB * cpb;
          for (int c = 1; c <= total; c++) begin
            if (c > 1) @(negedge clk);
            check($sformatf("%s_data_cyc%0d", tag, c), s_dout(w), f.bits[(c-1)/cpb]);
            check($sformatf("%s_done_cyc%0d", tag, c), s_done(w), (c == total));
            if (f.abort == c) break;
          end
          @(negedge clk);
          check({tag, "_after_ready"}, s_ready(w), 1'b1);
          check({tag, "_after_busy"},  s_busy(w),  1'b0);
          check({tag, "_after_line"},  s_dout(w),  1'b1);
          check({tag, "_after_done"},  s_done(w),  1'b0);
          if (f.b2b) begin
            @(negedge clk);
            check({tag, "_b2b_restart"}, s_busy(w), 1'b1);
            pending = 1'b1;
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // Offer one frame to instance A and release tx_valid after acceptance
  task automatic send_a(input logic [2:0] a, b, c, d, input logic [14:0] eb, input int ab);
    int k;
    k = 0;
    @(negedge clk);
    while (!tx_ready_a && k < 500) begin @(negedge clk); k++; end
    if (k >= 500) flag_fail("A_ready_timeout");
    r0a = a; r1a = b; r2a = c; r3a = d;
    qa.push_back(mkf(eb, ab, 1'b0));
    tx_valid_a = 1'b1;
    @(posedge clk);
    #1 tx_valid_a = 1'b0;
  endtask

  task automatic wait_idle;
    int k;
    k = 0;
    repeat (2) @(negedge clk);
    while ((busy_a || busy_b || qa.size() != 0 || qb.size() != 0) && k < 2000) begin
      @(negedge clk); k++;
    end
    if (k >= 2000) flag_fail("idle_timeout");
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] e5270, e1111;
    int k;
`ifdef SLOT_TX_PARITY_EN
    e5270 = 15'b100001110101010;
    e1111 = 15'b100010010010010;
`else
    e5270 = 15'b010001110101010;
    e1111 = 15'b010010010010010;
`endif
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready_a", tx_ready_a, 1'b1);
    check("rst_line_a",  data_out_a, 1'b1);
    check("rst_busy_a",  busy_a,     1'b0);
    check("rst_done_a",  done_a,     1'b0);
    check("rst_ready_b", tx_ready_b, 1'b1);
    check("rst_line_b",  data_out_b, 1'b1);
    reset = 1'b0;

    // Reference frame 5,2,7,0 and a second pattern from the model
    send_a(3'd5, 3'd2, 3'd7, 3'd0, e5270, 0);
    wait_idle();
    send_a(3'd3, 3'd6, 3'd1, 3'd4, model(3'd3, 3'd6, 3'd1, 3'd4), 0);
    wait_idle();

    // Request during DATA must be ignored and must not disturb the frame
    send_a(3'd1, 3'd1, 3'd1, 3'd1, e1111, 0);
    repeat (20) @(negedge clk);
    r0a = 3'd7; r1a = 3'd7; r2a = 3'd7; r3a = 3'd7;
    tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    wait_idle();
    check("no_second_accept", busy_a, 1'b0);

    // Reset in cycle 20 aborts the frame without done
    send_a(3'd6, 3'd5, 3'd4, 3'd3, model(3'd6, 3'd5, 3'd4, 3'd3), 20);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_idle();

    // Reset wins over a simultaneous request
    reset = 1'b1;
    tx_valid_a = 1'b1;
    r0a = 3'd2;
    @(negedge clk);
    check("rst_prio_busy",  busy_a,     1'b0);
    check("rst_prio_ready", tx_ready_a, 1'b1);
    reset = 1'b0;
    tx_valid_a = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_prio_stay_idle", busy_a, 1'b0);

    // Recovery after abort
    send_a(3'd5, 3'd2, 3'd7, 3'd0, e5270, 0);
    wait_idle();

    // Back-to-back frames at one clock per bit with tx_valid held high
    qb.push_back(mkf(model(3'd0, 3'd0, 3'd0, 3'd0), 0, 1'b1));
    qb.push_back(mkf(model(3'd0, 3'd0, 3'd0, 3'd0), 0, 1'b1));
    qb.push_back(mkf(model(3'd0, 3'd0, 3'd0, 3'd0), 0, 1'b0));
    @(negedge clk);
    tx_valid_b = 1'b1;
    for (int n = 0; n < 3; n++) begin
      k = 0;
      while (!tx_ready_b && k < 200) begin @(negedge clk); k++; end
      if (k >= 200) flag_fail("B_ready_timeout");
      @(posedge clk);
      if (n < 2) @(negedge clk);
    end
    #1 tx_valid_b = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
